// File: rtl/dcu_pkg.sv
// Shared decode-unit definitions: symbol encodings, FSM states and the
// extra-bit rules used by both the symbol decoder and the downstream text pool.
package dcu_pkg;

    typedef enum logic [2:0] {
        S_LL,
        S_EXTL,
        S_DIST,
        S_EXTD,
        S_ERR
    } dcu_state_t;

    localparam logic [5:0] SYM_LIT_BASE = 6'h00;
    localparam logic [5:0] SYM_LEN_BASE = 6'h10;
    localparam logic [5:0] SYM_EOB      = 6'h20;

    // Extra length bits: EL = L >> 1
    function automatic logic [2:0] el_bits(input logic [2:0] l);
        return l >> 1;
    endfunction

    // Extra distance bits: ED = (D < 2) ? 0 : (D >> 1) - 1
    function automatic logic [2:0] ed_bits(input logic [3:0] d);
        return (d < 4'd2) ? 3'd0 : 3'((d >> 1) - 4'd1);
    endfunction

endpackage

// File: rtl/dcu_bit_buf.sv
// LSB-first bit shift buffer: consumes bits from the bottom, appends whole
// bytes above the remaining bits, and can drop the partial-byte tail.
module dcu_bit_buf #(
    parameter int unsigned BUF_W = 16,
    localparam int unsigned CNT_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       byte_in,
    input  logic             push,
    input  logic [CNT_W-1:0] used,
    input  logic             align,
    output logic [5:0]       head,
    output logic [CNT_W-1:0] count
);

    logic [BUF_W-1:0] bits;
    logic [BUF_W-1:0] bits_nx;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] kept;
    logic [CNT_W-1:0] shift;

    assign head = bits[5:0];

    // Bits above count are always zero, so the new byte can simply be OR-ed in.
    always_comb begin
        rem     = count - used;
        drop    = align ? CNT_W'(rem[2:0]) : '0;
        kept    = rem - drop;
        shift   = used + drop;
        bits_nx = bits >> shift;
        if (push) begin
            bits_nx = bits_nx | (BUF_W'(byte_in) << kept);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bits  <= '0;
            count <= '0;
        end else begin
            bits  <= bits_nx;
            count <= kept + (push ? CNT_W'(8) : '0);
        end
    end

endmodule

// File: rtl/huff_sym_decoder.sv
// Prefix-code symbol decoder: pulls bytes from an upstream FIFO and pushes
// literal / match / end-of-block symbols, four symbols per match.
module huff_sym_decoder
    import dcu_pkg::*;
#(
    parameter int unsigned BUF_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_rempty,
    input  logic [7:0] in_data,
    output logic       in_rinc,
    input  logic       out_wfull,
    output logic       out_winc,
    output logic [5:0] out_symb,
    output logic       eob,
    output logic       err
);

    localparam int unsigned CNT_W = $clog2(BUF_W + 1);

    dcu_state_t       state, state_nx;
    logic [2:0]       len_q, len_nx;
    logic [3:0]       dist_q, dist_nx;
    logic             err_q, err_nx;
    logic [5:0]       head;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] used;
    logic [2:0]       need;
    logic [5:0]       field;
    logic [5:0]       symb;
    logic             have, push, align, is_eob, fault;

    dcu_bit_buf #(.BUF_W(BUF_W)) u_bit_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .byte_in (in_data),
        .push    (in_rinc),
        .used    (used),
        .align   (align),
        .head    (head),
        .count   (count)
    );

    assign field = head & ~(6'h3F << need);

    always_comb begin
        state_nx = state;
        len_nx   = len_q;
        dist_nx  = dist_q;
        err_nx   = err_q;
        need     = '0;
        symb     = '0;
        is_eob   = 1'b0;
        fault    = 1'b0;
        align    = 1'b0;

        // Field width is known from the prefix bits; when the prefix is not yet
        // buffered the assumed width exceeds count, so nothing fires early.
        case (state)
            S_LL: begin
                need = (!head[0] || !head[1]) ? 3'd5 : 3'd3;
                if (!head[0]) begin
                    symb = SYM_LIT_BASE | {2'b00, head[4:1]};
                end else if (!head[1]) begin
                    symb = SYM_LEN_BASE + {3'b000, head[4:2]};
                end else if (!head[2]) begin
                    symb   = SYM_EOB;
                    is_eob = 1'b1;
                end else begin
                    fault = 1'b1;
                end
            end
            S_EXTL: begin
                need = el_bits(len_q);
                symb = field;
            end
            S_DIST: begin
                need = 3'd4;
                symb = field;
            end
            S_EXTD: begin
                need = ed_bits(dist_q);
                symb = field;
            end
            default: need = '0;
        endcase

        have = (state != S_ERR) && (count >= CNT_W'(need));
        push = rst_n && have && !fault && !out_wfull;

        if (have && fault) begin
            state_nx = S_ERR;
            err_nx   = 1'b1;
        end else if (push) begin
            case (state)
                S_LL: begin
                    if (is_eob) begin
                        align = 1'b1;
                    end else if (head[0]) begin
                        len_nx   = head[4:2];
                        state_nx = S_EXTL;
                    end
                end
                S_EXTL: state_nx = S_DIST;
                S_DIST: begin
                    dist_nx  = head[3:0];
                    state_nx = S_EXTD;
                end
                S_EXTD: state_nx = S_LL;
                default: state_nx = state;
            endcase
        end
    end

    assign used     = push ? CNT_W'(need) : '0;
    assign out_winc = push;
    assign eob      = push && is_eob;
    assign out_symb = rst_n ? symb : '0;
    assign err      = err_q;
    assign in_rinc  = rst_n && (state != S_ERR) && (count <= CNT_W'(BUF_W - 8)) && !in_rempty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_LL;
            len_q  <= '0;
            dist_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            len_q  <= len_nx;
            dist_q <= dist_nx;
            err_q  <= err_nx;
        end
    end

endmodule

// File: tb/tb_huff_sym_decoder.sv
// Scoreboard bench for huff_sym_decoder: a bit-level encoder builds the byte
// stream and the expected symbol queue; a monitor compares every push.
module tb_huff_sym_decoder;

    localparam int unsigned BUF_W = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_rempty = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       out_wfull = 1'b0;
    logic       in_rinc, out_winc, eob, err;
    logic [5:0] out_symb;

    always #5 clk = ~clk;

    huff_sym_decoder #(.BUF_W(BUF_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_rempty (in_rempty),
        .in_data   (in_data),
        .in_rinc   (in_rinc),
        .out_wfull (out_wfull),
        .out_winc  (out_winc),
        .out_symb  (out_symb),
        .eob       (eob),
        .err       (err)
    );

    typedef struct packed {
        logic [5:0] symb;
        logic       eob;
    } exp_t;

    logic [7:0] bq[$];
    exp_t       eq[$];
    bit         bitq[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_pop = 0;
    int last_push = 0;
    bit burst = 0;
    bit lat_chk = 0;
    bit hold_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: refresh FIFO view on negedge, then sample the combinational handshakes.
    initial begin : monitor
        exp_t       cur;
        bit         burst_seen;
        bit         lat_done;
        bit         prev_stall;
        logic [5:0] prev_symb;
        burst_seen = 0;
        lat_done   = 0;
        prev_stall = 0;
        prev_symb  = '0;
        forever begin
            @(negedge clk);
            in_rempty = (bq.size() == 0);
            in_data   = (bq.size() == 0) ? 8'h00 : bq[0];
            #1;
            cyc++;
            if (!rst_n) begin
                check("rst_rinc", 32'(in_rinc), 32'(0));
                check("rst_winc", 32'(out_winc), 32'(0));
                check("rst_eob", 32'(eob), 32'(0));
                check("rst_symb", 32'(out_symb), 32'(0));
            end else begin
                if (in_rinc) begin
                    check("rinc_when_empty", 32'(in_rempty), 32'(0));
                    if (bq.size() > 0) void'(bq.pop_front());
                    last_pop = cyc;
                end
                if (err) check("rinc_in_err", 32'(in_rinc), 32'(0));
                if (out_winc) begin
                    check("push_while_full", 32'(out_wfull), 32'(0));
                    if (eq.size() == 0) begin
                        check("spurious_push", 32'(out_winc), 32'(0));
                    end else begin
                        cur = eq.pop_front();
                        check("symb", 32'(out_symb), 32'(cur.symb));
                        check("eob", 32'(eob), 32'(cur.eob));
                    end
                    if (burst && burst_seen) check("burst_gap", 32'(cyc - last_push), 32'(1));
                    if (lat_chk && !lat_done) begin
                        check("latency", 32'(cyc - last_pop), 32'(1));
                        lat_done = 1;
                    end
                    burst_seen = burst;
                    last_push  = cyc;
                end else if (eob) begin
                    check("eob_no_push", 32'(eob), 32'(0));
                end
                if (!burst) burst_seen = 0;
                if (!lat_chk) lat_done = 0;
                if (hold_chk && out_wfull) begin
                    if (prev_stall) check("stall_hold", 32'(out_symb), 32'(prev_symb));
                    prev_stall = 1;
                    prev_symb  = out_symb;
                end else begin
                    prev_stall = 0;
                end
            end
        end
    end

    task automatic expect_sym(input logic [5:0] s, input logic e);
        exp_t t;
        t.symb = s;
        t.eob  = e;
        eq.push_back(t);
    endtask

    task automatic put_bits(input logic [31:0] v, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) bitq.push_back(v[i]);
    endtask

    task automatic flush_bytes();
        logic [7:0] b;
        while (bitq.size() % 8 != 0) bitq.push_back(1'b0);
        while (bitq.size() != 0) begin
            for (int i = 0; i < 8; i++) b[i] = bitq.pop_front();
            bq.push_back(b);
        end
    endtask

    task automatic enc_lit(input logic [3:0] nib);
        put_bits(32'(0), 1);
        put_bits(32'(nib), 4);
        expect_sym({2'b00, nib}, 1'b0);
    endtask

    task automatic enc_match(input logic [2:0] l, input logic [3:0] d);
        int unsigned el, ed;
        logic [31:0] ev, dv;
        el = 32'(l) >> 1;
        ed = (d < 4'd2) ? 0 : (32'(d) >> 1) - 1;
        ev = 32'($urandom_range(0, (1 << el) - 1));
        dv = 32'($urandom_range(0, (1 << ed) - 1));
        put_bits(32'(1), 1);
        put_bits(32'(0), 1);
        put_bits(32'(l), 3);
        expect_sym(6'(16 + 32'(l)), 1'b0);
        put_bits(ev, el);
        expect_sym(6'(ev), 1'b0);
        put_bits(32'(d), 4);
        expect_sym({2'b00, d}, 1'b0);
        put_bits(dv, ed);
        expect_sym(6'(dv), 1'b0);
    endtask

    task automatic enc_eob();
        put_bits(32'(3), 2);
        put_bits(32'(0), 1);
        expect_sym(6'h20, 1'b1);
        flush_bytes();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bq.delete();
        eq.delete();
        bitq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (eq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(eq.size()), 32'(0));
        eq.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("err_after_reset", 32'(err), 32'(0));
        check("idle_winc", 32'(out_winc), 32'(0));

        // single literal + end-of-block, first-push latency
        lat_chk = 1;
        bq.push_back(8'h74);
        expect_sym(6'h0A, 1'b0);
        expect_sym(6'h20, 1'b1);
        wait_drain(50);
        lat_chk = 0;

        // length/distance match followed by end-of-block
        bq.push_back(8'hF5);
        bq.push_back(8'h19);
        expect_sym(6'h15, 1'b0);
        expect_sym(6'h03, 1'b0);
        expect_sym(6'h03, 1'b0);
        expect_sym(6'h00, 1'b0);
        expect_sym(6'h20, 1'b1);
        wait_drain(50);

        // same match with a 5-cycle backpressure stall after the first push
        hold_chk = 1;
        bq.push_back(8'hF5);
        bq.push_back(8'h19);
        expect_sym(6'h15, 1'b0);
        expect_sym(6'h03, 1'b0);
        expect_sym(6'h03, 1'b0);
        expect_sym(6'h00, 1'b0);
        expect_sym(6'h20, 1'b1);
        n = 0;
        while (eq.size() > 4 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        out_wfull = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("stall_no_push", 32'(eq.size()), 32'(4));
        out_wfull = 1'b0;
        wait_drain(50);
        hold_chk = 0;

        // reset in the middle of a match discards buffered bits
        bq.push_back(8'hF5);
        expect_sym(6'h15, 1'b0);
        expect_sym(6'h03, 1'b0);
        wait_drain(50);
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        bq.push_back(8'h74);
        expect_sym(6'h0A, 1'b0);
        expect_sym(6'h20, 1'b1);
        wait_drain(50);

        // literal burst: one push per cycle
        burst = 1;
        for (int i = 0; i < 16; i++) enc_lit(4'($urandom_range(0, 15)));
        flush_bytes();
        wait_drain(100);
        burst = 0;

        // random blocks mixing literals and matches, each ending unaligned
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                if ($urandom_range(0, 1) == 0) enc_lit(4'($urandom_range(0, 15)));
                else enc_match(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            end
            enc_eob();
        end
        wait_drain(600);

        // reserved prefix: sticky error, no pops, no pushes
        bq.push_back(8'h07);
        n = 0;
        while (!err && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("err_set", 32'(err), 32'(1));
        check("err_prompt", 32'(n <= 3), 32'(1));
        bq.push_back(8'h74);
        repeat (6) @(posedge clk);
        #1;
        check("err_no_pop", 32'(bq.size()), 32'(1));
        check("err_sticky", 32'(err), 32'(1));
        do_reset();
        #1;
        check("err_cleared", 32'(err), 32'(0));
        bq.push_back(8'h74);
        expect_sym(6'h0A, 1'b0);
        expect_sym(6'h20, 1'b1);
        wait_drain(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
